uart_word_tx_fifo: RTL and testbench
====================================

# uart_word_tx_fifo

Transmit-side counterpart of the receive byte-to-word assembler. It queues 32-bit words (or 1–3-byte fragments of them) written by the pipeline's register-to-UART path and serialises them into single bytes for the UART `sender`, pacing each byte against `sender_ready`. It sits between the execution stage's UART write request and the `sender` instance, replacing direct single-word handoff with a buffered queue.

## Interface
- `DEPTH_LOG2`, default 4: queue holds 2^DEPTH_LOG2 entries (16).
- `CLK` in, 1: system clock.
- `reset` in, 1: asynchronous, active-high reset.
- `wr_data` in, 32: word to transmit.
- `wr_len` in, 2: byte count minus 1; 0 sends 1 byte, 3 sends 4 bytes.
- `wr_enable` in, 1: push `{wr_data, wr_len}` on the rising edge.
- `full` out, 1: registered; queue holds 2^DEPTH_LOG2 entries.
- `empty` out, 1: registered; queue empty and serialiser in IDLE.
- `overflow` out, 1: sticky; a write was dropped. Cleared only by `reset`.
- `level` out, DEPTH_LOG2+1: number of queued entries, excluding the word being serialised.
- `sender_ready` in, 1: `sender` is idle and can accept a byte.
- `sender_data` out, 8: byte to `sender`; registered.
- `sender_enable` out, 1: one-cycle strobe; registered.

## Operation
- Queue entry is {len[1:0], data[31:0]}. Active bytes are data[8·len+7:0], sent most-significant active byte first. Example: len=1 sends data[15:8], then data[7:0].
- Serialiser FSM:
  - IDLE: if the queue is non-empty, pop the head into the shift register, set remaining = len+1, go to SEND.
  - SEND: when `sender_ready`=1, register `sender_data` = current byte and `sender_enable` = 1, decrement remaining, go to STROBE. Otherwise hold.
  - STROBE: `sender_enable` is high this cycle. Clear it at the edge and go to SETTLE.
  - SETTLE: ignore `sender_ready` for one cycle so `sender` can drop it. Then go to SEND if remaining > 0, else IDLE.
- Push when `wr_enable`=1 and `full`=0. When `wr_enable`=1 and `full`=1, the write is dropped and `overflow` is set. This applies even if a pop happens in the same cycle.
- Simultaneous push and pop with the queue non-full: `level` is unchanged and both pointers advance.
- Pointers wrap modulo 2^DEPTH_LOG2. `level` saturates only by construction (full blocks push). A pop never occurs when empty.
- No bypass: a write to an empty queue still passes through storage.
- `sender_data` holds its last value when `sender_enable`=0.

## Timing
- Reset values: `sender_enable`=0, `sender_data`=0, `full`=0, `empty`=1, `overflow`=0, `level`=0, FSM=IDLE, pointers=0.
- Reset asserted mid-word: all outputs go to reset values immediately (asynchronous). The partially sent word and all queued words are discarded.
- Latency with `sender_ready`=1 throughout:
  - Write at edge E: pop at E+1, first `sender_enable` high in cycle E+2..E+3 (registered at E+2).
  - Byte period is 3 cycles (SEND, STROBE, SETTLE).
  - Word-to-word gap adds 1 IDLE cycle, so a 4-byte word occupies 13 cycles.
- `sender_enable` is never high on two consecutive cycles.
- `sender_enable` is asserted only following a cycle in which `sender_ready`=1 was sampled in SEND.
- `full`, `empty` and `level` update on the edge following the push or pop.

## Structure
- Package `uart_tx_pkg`:
  - `tx_state_t` enum {IDLE, SEND, STROBE, SETTLE}.
  - `tx_len_t` (2 bits).
  - `tx_entry_t` packed struct {len, data}.
  - constant `TX_BYTE_W` = 8.
- Sub-module `tx_word_fifo`:
  - parameterised DEPTH_LOG2 storage array plus read/write pointers.
  - `level`, `full`, `empty_q`, `overflow`.
  - first-word-fallthrough head output.
- Top: the FSM and shift register. `empty` = `empty_q` and FSM==IDLE.

## Test plan
- Reset, then write 0x41424344 with len=3, `sender_ready` held at 1 → strobes carry 0x41, 0x42, 0x43, 0x44, spaced 3 cycles apart. First strobe registered 2 edges after the write. `empty`=1 after the last SETTLE.
- Write 0x0000ABCD with len=1, then 0x000000EF with len=0 on consecutive cycles → bytes 0xAB, 0xCD, 0xEF. `level` goes 1, then 1, then 0.
- `sender_ready` dropped to 0 for 20 cycles while in SEND → `sender_enable` stays 0 and `sender_data` is stable. The byte is strobed 1 edge after `sender_ready` returns to 1.
- DEPTH_LOG2=4, 17 writes with `sender_ready`=0 and 1 entry popped into the shift register → 16 entries queued, `full`=1, no overflow. An 18th write is dropped with `overflow`=1. Then all 17 words drain in order.
- Push on the same cycle as a pop while `full`=1 → write dropped, `overflow`=1, `level`=15.
- Assert `reset` during the second byte of a 4-byte word → `sender_enable`=0 immediately and `level`=0. After release, a new write 0x55 with len=0 sends only 0x55.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types for the UART word transmit queue: serialiser states and queue entry layout.
package uart_tx_pkg;

    localparam int TX_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        STROBE = 2'd2,
        SETTLE = 2'd3
    } tx_state_t;

    typedef logic [1:0] tx_len_t;

    typedef struct packed {
        tx_len_t     len;
        logic [31:0] data;
    } tx_entry_t;

    // Left-justify the active bytes so the serialiser always takes bits [31:24] next.
    function automatic logic [31:0] align_msb(input tx_entry_t entry);
        logic [31:0] aligned;
        case (entry.len)
            2'd0:    aligned = {entry.data[7:0], 24'h000000};
            2'd1:    aligned = {entry.data[15:0], 16'h0000};
            2'd2:    aligned = {entry.data[23:0], 8'h00};
            default: aligned = entry.data;
        endcase
        return aligned;
    endfunction

endpackage

// File: rtl/tx_word_fifo.sv
// Word queue for the UART transmitter: 2^DEPTH_LOG2 entries, first-word-fallthrough head,
// registered level/full/empty and a sticky overflow flag for dropped writes.
module tx_word_fifo
    import uart_tx_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  tx_entry_t             wr_entry,
    input  logic                  wr_enable,
    input  logic                  rd_enable,
    output tx_entry_t             head,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty_q,
    output logic                  overflow
);

    localparam int                 DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

    tx_entry_t                 mem_reg [DEPTH];
    logic [DEPTH_LOG2-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [DEPTH_LOG2:0]       level_reg, level_next;
    logic                      full_reg, empty_reg, overflow_reg;
    logic                      push, pop;

    // A full queue drops the write even when a pop frees a slot in the same cycle.
    assign push = wr_enable & ~full_reg;
    assign pop  = rd_enable & ~empty_reg;

    always_comb begin
        level_next = level_reg;
        if (push && !pop) begin
            level_next = level_reg + (DEPTH_LOG2 + 1)'(1);
        end else if (!push && pop) begin
            level_next = level_reg - (DEPTH_LOG2 + 1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= wr_entry;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
            end
            if (wr_enable && full_reg) begin
                overflow_reg <= 1'b1;
            end
            level_reg <= level_next;
            full_reg  <= (level_next == LEVEL_MAX);
            empty_reg <= (level_next == '0);
        end
    end

    assign head     = mem_reg[rd_ptr_reg];
    assign level    = level_reg;
    assign full     = full_reg;
    assign empty_q  = empty_reg;
    assign overflow = overflow_reg;

endmodule

// File: rtl/uart_word_tx_fifo.sv
// Buffered word-to-byte serialiser feeding the UART sender: queues 1-4 byte words and
// strobes them out most-significant active byte first, paced by sender_ready.
module uart_word_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic [31:0]            wr_data,
    input  logic [1:0]             wr_len,
    input  logic                   wr_enable,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic [DEPTH_LOG2:0]    level,
    input  logic                   sender_ready,
    output logic [TX_BYTE_W-1:0]   sender_data,
    output logic                   sender_enable
);

    tx_state_t               state_reg, state_next;
    logic [31:0]             shift_reg, shift_next;
    logic [2:0]              remaining_reg, remaining_next;
    logic [TX_BYTE_W-1:0]    sender_data_reg, sender_data_next;
    logic                    sender_enable_reg, sender_enable_next;
    logic                    pop;
    logic                    empty_q;
    tx_entry_t               wr_entry, head;

    assign wr_entry = '{len: wr_len, data: wr_data};
    assign pop      = (state_reg == IDLE) && !empty_q;

    tx_word_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .CLK       (CLK),
        .reset     (reset),
        .wr_entry  (wr_entry),
        .wr_enable (wr_enable),
        .rd_enable (pop),
        .head      (head),
        .level     (level),
        .full      (full),
        .empty_q   (empty_q),
        .overflow  (overflow)
    );

    always_comb begin
        state_next         = state_reg;
        shift_next         = shift_reg;
        remaining_next     = remaining_reg;
        sender_data_next   = sender_data_reg;
        sender_enable_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty_q) begin
                    shift_next     = align_msb(head);
                    remaining_next = {1'b0, head.len} + 3'd1;
                    state_next     = SEND;
                end
            end
            SEND: begin
                if (sender_ready) begin
                    sender_data_next   = shift_reg[31 -: TX_BYTE_W];
                    sender_enable_next = 1'b1;
                    shift_next         = shift_reg << TX_BYTE_W;
                    remaining_next     = remaining_reg - 3'd1;
                    state_next         = STROBE;
                end
            end
            STROBE: begin
                state_next = SETTLE;
            end
            // Extra cycle lets the sender drop sender_ready before it is sampled again.
            SETTLE: begin
                state_next = (remaining_reg != 3'd0) ? SEND : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            shift_reg         <= '0;
            remaining_reg     <= '0;
            sender_data_reg   <= '0;
            sender_enable_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            shift_reg         <= shift_next;
            remaining_reg     <= remaining_next;
            sender_data_reg   <= sender_data_next;
            sender_enable_reg <= sender_enable_next;
        end
    end

    assign empty         = empty_q && (state_reg == IDLE);
    assign sender_data   = sender_data_reg;
    assign sender_enable = sender_enable_reg;

endmodule

// File: tb/tb_uart_word_tx_fifo.sv
// Directed self-checking bench for uart_word_tx_fifo: byte order, pacing, back-pressure,
// full/overflow handling and asynchronous reset mid-word.
module tb_uart_word_tx_fifo;

    logic        CLK = 1'b0;
    logic        reset;
    logic [31:0] wr_data;
    logic [1:0]  wr_len;
    logic        wr_enable;
    logic        full, empty, overflow;
    logic [4:0]  level;
    logic        sender_ready;
    logic [7:0]  sender_data;
    logic        sender_enable;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] got_data[$];
    int         got_cyc[$];
    logic       prev_en    = 1'b0;
    logic       prev_ready = 1'b0;

    uart_word_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .CLK           (CLK),
        .reset         (reset),
        .wr_data       (wr_data),
        .wr_len        (wr_len),
        .wr_enable     (wr_enable),
        .full          (full),
        .empty         (empty),
        .overflow      (overflow),
        .level         (level),
        .sender_ready  (sender_ready),
        .sender_data   (sender_data),
        .sender_enable (sender_enable)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: records each byte with its edge count and checks pacing rules.
    always @(negedge CLK) begin
        if (!reset && sender_enable) begin
            got_data.push_back(sender_data);
            got_cyc.push_back(cyc);
            chk("no_back_to_back", {31'b0, prev_en}, 32'd0);
            chk("ready_before_strobe", {31'b0, prev_ready}, 32'd1);
        end
        prev_en    = sender_enable;
        prev_ready = sender_ready;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_word(input logic [31:0] d, input logic [1:0] l, output int e);
        wr_data   = d;
        wr_len    = l;
        wr_enable = 1'b1;
        @(posedge CLK);
        #1;
        e         = cyc;
        wr_enable = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int k = 0;
        while (got_data.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("strobe_count", got_data.size(), n);
    endtask

    task automatic wait_empty(input int budget);
        int k = 0;
        while (!empty && k < budget) begin
            tick();
            k++;
        end
        chk("wait_empty", {31'b0, empty}, 32'd1);
    endtask

    task automatic clear_log();
        got_data.delete();
        got_cyc.delete();
    endtask

    initial begin
        int e, e0, e1, c;
        reset        = 1'b1;
        wr_data      = '0;
        wr_len       = '0;
        wr_enable    = 1'b0;
        sender_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_sender_enable", {31'b0, sender_enable}, 32'd0);
        chk("rst_sender_data", {24'b0, sender_data}, 32'd0);
        chk("rst_full", {31'b0, full}, 32'd0);
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_overflow", {31'b0, overflow}, 32'd0);
        chk("rst_level", {27'b0, level}, 32'd0);
        reset = 1'b0;
        tick();

        // Four-byte word, ready held high
        clear_log();
        write_word(32'h41424344, 2'd3, e);
        wait_strobes(4, 30);
        for (int i = 0; i < 4; i++) begin
            chk("w4_byte", {24'b0, got_data[i]}, 32'h41 + i);
            chk("w4_cycle", got_cyc[i], e + 2 + 3 * i);
        end
        while (cyc < e + 12) tick();
        chk("w4_empty_in_settle", {31'b0, empty}, 32'd0);
        tick();
        chk("w4_empty_after", {31'b0, empty}, 32'd1);

        // Two-byte then one-byte word on consecutive cycles
        clear_log();
        write_word(32'h0000ABCD, 2'd1, e0);
        chk("lvl_after_first", {27'b0, level}, 32'd1);
        write_word(32'h000000EF, 2'd0, e1);
        chk("lvl_after_second", {27'b0, level}, 32'd1);
        wait_strobes(3, 40);
        chk("w2_byte0", {24'b0, got_data[0]}, 32'hAB);
        chk("w2_byte1", {24'b0, got_data[1]}, 32'hCD);
        chk("w2_byte2", {24'b0, got_data[2]}, 32'hEF);
        chk("w2_cyc0", got_cyc[0], e0 + 2);
        chk("w2_cyc1", got_cyc[1], e0 + 5);
        chk("w2_cyc2", got_cyc[2], e0 + 9);
        chk("lvl_drained", {27'b0, level}, 32'd0);
        wait_empty(20);

        // Back-pressure: sender_ready low for 20 cycles in SEND
        clear_log();
        sender_ready = 1'b0;
        write_word(32'h000000A5, 2'd0, e);
        repeat (20) tick();
        chk("stall_no_strobe", got_data.size(), 0);
        chk("stall_data_stable", {24'b0, sender_data}, 32'hEF);
        chk("stall_enable_low", {31'b0, sender_enable}, 32'd0);
        sender_ready = 1'b1;
        c = cyc;
        wait_strobes(1, 10);
        chk("stall_byte", {24'b0, got_data[0]}, 32'hA5);
        chk("stall_cycle", got_cyc[0], c + 1);
        wait_empty(20);

        // Fill to full, drop one write, drain in order
        clear_log();
        sender_ready = 1'b0;
        for (int i = 0; i < 17; i++) write_word(32'h60 + i, 2'd0, e);
        chk("fill_level", {27'b0, level}, 32'd16);
        chk("fill_full", {31'b0, full}, 32'd1);
        chk("fill_no_overflow", {31'b0, overflow}, 32'd0);
        write_word(32'hEE, 2'd0, e);
        chk("drop_overflow", {31'b0, overflow}, 32'd1);
        chk("drop_level", {27'b0, level}, 32'd16);
        sender_ready = 1'b1;
        wait_strobes(17, 100);
        for (int i = 0; i < 17; i++) chk("drain_order", {24'b0, got_data[i]}, 32'h60 + i);
        wait_empty(20);
        chk("drain_level", {27'b0, level}, 32'd0);
        chk("drain_full", {31'b0, full}, 32'd0);

        // Write coinciding with a pop while full is dropped
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_overflow", {31'b0, overflow}, 32'd0);
        clear_log();
        sender_ready = 1'b0;
        for (int i = 0; i < 17; i++) write_word(32'h80 + i, 2'd0, e);
        chk("fill2_full", {31'b0, full}, 32'd1);
        chk("fill2_overflow", {31'b0, overflow}, 32'd0);
        sender_ready = 1'b1;
        tick();
        tick();
        tick();
        write_word(32'hDD, 2'd0, e);
        chk("pushpop_overflow", {31'b0, overflow}, 32'd1);
        chk("pushpop_level", {27'b0, level}, 32'd15);
        chk("pushpop_full", {31'b0, full}, 32'd0);
        wait_strobes(16, 100);
        chk("pushpop_first", {24'b0, got_data[0]}, 32'h80);
        chk("pushpop_last", {24'b0, got_data[15]}, 32'h8F);
        wait_empty(20);

        // Asynchronous reset during the second byte of a four-byte word
        write_word(32'h41424344, 2'd3, e);
        write_word(32'h00000099, 2'd0, e1);
        chk("mid_level", {27'b0, level}, 32'd1);
        while (cyc < e + 5) tick();
        chk("mid_strobe", {31'b0, sender_enable}, 32'd1);
        chk("mid_byte", {24'b0, sender_data}, 32'h42);
        #2;
        reset = 1'b1;
        #1;
        chk("async_enable", {31'b0, sender_enable}, 32'd0);
        chk("async_level", {27'b0, level}, 32'd0);
        chk("async_data", {24'b0, sender_data}, 32'd0);
        chk("async_empty", {31'b0, empty}, 32'd1);
        tick();
        reset = 1'b0;
        clear_log();
        write_word(32'h00000055, 2'd0, e);
        wait_strobes(1, 10);
        repeat (30) tick();
        chk("post_rst_count", got_data.size(), 1);
        chk("post_rst_byte", {24'b0, got_data[0]}, 32'h55);
        chk("post_rst_cycle", got_cyc[0], e + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
